// File: rtl/pipe_stage_skid.sv
// Handshaked pipeline stage register with an optional two-entry skid buffer.
// Carries an opaque payload; flush squashes held entries to the bubble value.
//
// state   | meaning
// --------+------------------------------------------------------------
// StEmpty | nothing held, OutData = ClearValue
// StOne   | main register holds the head entry
// StFull  | main holds the head, skid holds the next entry (SkidEnable=1)
module pipe_stage_skid #(
    parameter int               Width      = 64,
    parameter logic [Width-1:0] ClearValue = {Width{1'b0}},
    parameter bit               SkidEnable = 1'b1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Flush,
    input  logic             InValid,
    output logic             InReady,
    input  logic [Width-1:0] InData,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [Width-1:0] OutData,
    output logic [1:0]       Count
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } stateT;

    stateT            state;
    stateT            stateNext;
    logic [Width-1:0] mainQ;
    logic [Width-1:0] mainNext;
    logic [Width-1:0] skidQ;
    logic [Width-1:0] skidNext;
    logic             canAccept;
    logic             inXfer;
    logic             outXfer;

    // Without a skid entry, a held item must leave in the same cycle a new one arrives.
    assign canAccept = SkidEnable ? (state != StFull)
                                  : ((state == StEmpty) | OutReady);
    assign InReady   = canAccept & ~Rst & ~Flush;
    assign OutValid  = (state != StEmpty);
    assign OutData   = mainQ;
    assign Count     = 2'(state);
    assign inXfer    = InValid & InReady;
    assign outXfer   = OutValid & OutReady;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= StEmpty;
            mainQ <= ClearValue;
            skidQ <= ClearValue;
        end else begin
            state <= stateNext;
            mainQ <= mainNext;
            skidQ <= skidNext;
        end
    end

    // mainQ is kept at ClearValue whenever the stage is empty so OutData stays a pure register.
    always_comb begin
        stateNext = state;
        mainNext  = mainQ;
        skidNext  = skidQ;
        if (Rst || Flush) begin
            stateNext = StEmpty;
            mainNext  = ClearValue;
            skidNext  = ClearValue;
        end else begin
            unique case (state)
                StEmpty: begin
                    if (inXfer) begin
                        mainNext  = InData;
                        stateNext = StOne;
                    end
                end
                StOne: begin
                    if (inXfer && outXfer) begin
                        mainNext = InData;
                    end else if (inXfer) begin
                        skidNext  = InData;
                        stateNext = StFull;
                    end else if (outXfer) begin
                        mainNext  = ClearValue;
                        stateNext = StEmpty;
                    end
                end
                StFull: begin
                    if (outXfer) begin
                        mainNext  = skidQ;
                        skidNext  = ClearValue;
                        stateNext = StOne;
                    end
                end
                default: begin
                    stateNext = StEmpty;
                    mainNext  = ClearValue;
                    skidNext  = ClearValue;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: a skid instance and a single-entry instance,
// each with a FIFO scoreboard of accepted payloads.
module tb_pipe_stage_skid;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush1, valid1, ready1, oValid1, oReady1;
    logic [7:0] data1, oData1;
    logic [1:0] count1;
    logic       flush0, valid0, ready0, oValid0, oReady0;
    logic [7:0] data0, oData0;
    logic [1:0] count0;
    int         total = 0;
    int         bad = 0;
    logic [7:0] sb1[$];
    logic [7:0] sb0[$];

    always #5 clk = ~clk;

    pipe_stage_skid #(.Width(8), .ClearValue(8'hEE), .SkidEnable(1'b1)) dutSkid (
        .Clk(clk), .Rst(rst), .Flush(flush1),
        .InValid(valid1), .InReady(ready1), .InData(data1),
        .OutValid(oValid1), .OutReady(oReady1), .OutData(oData1), .Count(count1)
    );

    pipe_stage_skid #(.Width(8), .ClearValue(8'hEE), .SkidEnable(1'b0)) dutReg (
        .Clk(clk), .Rst(rst), .Flush(flush0),
        .InValid(valid0), .InReady(ready0), .InData(data0),
        .OutValid(oValid0), .OutReady(oReady0), .OutData(oData0), .Count(count0)
    );

    // One clock: observe transfers at the falling edge, then return #1 after the rising edge.
    task automatic step();
        logic       inX1, outX1, inX0, outX0;
        logic [7:0] exp;
        @(negedge clk);
        inX1  = valid1 & ready1;
        outX1 = oValid1 & oReady1;
        inX0  = valid0 & ready0;
        outX0 = oValid0 & oReady0;
        if (!oValid1) begin
            total++;
            if (oData1 !== 8'hEE) begin bad++; $display("FAIL bubble1 got=%h exp=ee", oData1); end
        end
        if (!oValid0) begin
            total++;
            if (oData0 !== 8'hEE) begin bad++; $display("FAIL bubble0 got=%h exp=ee", oData0); end
        end
        if (rst || flush1) sb1.delete();
        else begin
            if (outX1) begin
                total++;
                if (sb1.size() == 0) begin bad++; $display("FAIL unexpected1 got=%h exp=none", oData1); end
                else begin
                    exp = sb1.pop_front();
                    if (oData1 !== exp) begin bad++; $display("FAIL order1 got=%h exp=%h", oData1, exp); end
                end
            end
            if (inX1) sb1.push_back(data1);
        end
        if (rst || flush0) sb0.delete();
        else begin
            if (outX0) begin
                total++;
                if (sb0.size() == 0) begin bad++; $display("FAIL unexpected0 got=%h exp=none", oData0); end
                else begin
                    exp = sb0.pop_front();
                    if (oData0 !== exp) begin bad++; $display("FAIL order0 got=%h exp=%h", oData0, exp); end
                end
            end
            if (inX0) sb0.push_back(data0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush1 = 1'b0; flush0 = 1'b0;
        valid1 = 1'b1; data1 = 8'h11; oReady1 = 1'b1;
        valid0 = 1'b1; data0 = 8'h11; oReady0 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if (oValid1 !== 1'b0 || oData1 !== 8'hEE || count1 !== 2'd0 || ready1 !== 1'b0) begin
                bad++; $display("FAIL reset1 got v=%b d=%h c=%0d r=%b exp v=0 d=ee c=0 r=0", oValid1, oData1, count1, ready1);
            end
            total++;
            if (oValid0 !== 1'b0 || oData0 !== 8'hEE || count0 !== 2'd0 || ready0 !== 1'b0) begin
                bad++; $display("FAIL reset0 got v=%b d=%h c=%0d r=%b exp v=0 d=ee c=0 r=0", oValid0, oData0, count0, ready0);
            end
        end
        rst = 1'b0; valid1 = 1'b0; valid0 = 1'b0;
        #1;
        total++;
        if (ready1 !== 1'b1 || ready0 !== 1'b1 || oValid1 !== 1'b0) begin
            bad++; $display("FAIL post_reset got r1=%b r0=%b v1=%b exp 1 1 0", ready1, ready0, oValid1);
        end
        step(); step();
    endtask

    task automatic test_streaming();
        oReady1 = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            valid1 = 1'b1; data1 = 8'(i);
            step();
            total++;
            if (oValid1 !== 1'b1 || oData1 !== 8'(i)) begin
                bad++; $display("FAIL stream_latency got v=%b d=%h exp v=1 d=%h", oValid1, oData1, 8'(i));
            end
            total++;
            if (ready1 !== 1'b1 || count1 > 2'd1) begin
                bad++; $display("FAIL stream_flow got r=%b c=%0d exp r=1 c<=1", ready1, count1);
            end
        end
        valid1 = 1'b0;
        step(); step();
    endtask

    task automatic test_backpressure();
        oReady1 = 1'b0; valid1 = 1'b1;
        data1 = 8'hA1; step();
        data1 = 8'hA2; step();
        data1 = 8'hA3; #1;
        total++;
        if (ready1 !== 1'b0 || count1 !== 2'd2) begin
            bad++; $display("FAIL bp_full got r=%b c=%0d exp r=0 c=2", ready1, count1);
        end
        step(); step();
        total++;
        if (count1 !== 2'd2 || oData1 !== 8'hA1) begin
            bad++; $display("FAIL bp_hold got c=%0d d=%h exp c=2 d=a1", count1, oData1);
        end
        oReady1 = 1'b1;
        step(); step();
        valid1 = 1'b0;
        step(); step();
        total++;
        if (sb1.size() != 0 || oValid1 !== 1'b0) begin
            bad++; $display("FAIL bp_drain got left=%0d v=%b exp left=0 v=0", sb1.size(), oValid1);
        end
    endtask

    task automatic test_flush_full();
        oReady1 = 1'b0; valid1 = 1'b1;
        data1 = 8'hB1; step();
        data1 = 8'hB2; step();
        total++;
        if (count1 !== 2'd2) begin bad++; $display("FAIL flush_pre got c=%0d exp c=2", count1); end
        flush1 = 1'b1; data1 = 8'h55;
        step();
        total++;
        if (count1 !== 2'd0 || oValid1 !== 1'b0 || oData1 !== 8'hEE) begin
            bad++; $display("FAIL flush_full got c=%0d v=%b d=%h exp c=0 v=0 d=ee", count1, oValid1, oData1);
        end
        flush1 = 1'b0; valid1 = 1'b0; oReady1 = 1'b1;
        step(); step();
    endtask

    task automatic test_hold();
        oReady1 = 1'b0; valid1 = 1'b1; data1 = 8'hC3;
        step();
        for (int k = 0; k < 5; k++) begin
            data1 = 8'($urandom);
            step();
            total++;
            if (oValid1 !== 1'b1 || oData1 !== 8'hC3) begin
                bad++; $display("FAIL hold got v=%b d=%h exp v=1 d=c3", oValid1, oData1);
            end
        end
        valid1 = 1'b0; oReady1 = 1'b1;
        step(); step(); step();
        total++;
        if (sb1.size() != 0) begin bad++; $display("FAIL hold_drain got left=%0d exp left=0", sb1.size()); end
    endtask

    task automatic test_mid_reset();
        oReady1 = 1'b0; valid1 = 1'b1;
        data1 = 8'h71; step();
        data1 = 8'h72; step();
        rst = 1'b1; step();
        rst = 1'b0; valid1 = 1'b0; oReady1 = 1'b1; #1;
        total++;
        if (count1 !== 2'd0 || oValid1 !== 1'b0 || oData1 !== 8'hEE || ready1 !== 1'b1) begin
            bad++; $display("FAIL mid_reset got c=%0d v=%b d=%h r=%b exp c=0 v=0 d=ee r=1", count1, oValid1, oData1, ready1);
        end
        step(); step();
    endtask

    task automatic test_noskid();
        valid0 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            oReady0 = (i % 2 == 0); data0 = 8'(8'hD0 + i);
            #1;
            total++;
            if (count0 > 2'd1) begin bad++; $display("FAIL noskid_count got c=%0d exp c<=1", count0); end
            if (oValid0) begin
                total++;
                if (ready0 !== oReady0) begin bad++; $display("FAIL noskid_ready got r=%b exp r=%b", ready0, oReady0); end
            end
            step();
        end
        oReady0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data0 = 8'(8'hE0 + i);
            #1;
            total++;
            if (ready0 !== 1'b1) begin bad++; $display("FAIL noskid_stream got r=%b exp r=1", ready0); end
            step();
        end
        valid0 = 1'b0;
        step(); step();
        total++;
        if (sb0.size() != 0 || oValid0 !== 1'b0) begin
            bad++; $display("FAIL noskid_drain got left=%0d v=%b exp left=0 v=0", sb0.size(), oValid0);
        end
    endtask

    initial begin
        rst = 1'b1; flush1 = 1'b0; flush0 = 1'b0;
        valid1 = 1'b0; valid0 = 1'b0; oReady1 = 1'b0; oReady0 = 1'b0;
        data1 = 8'h00; data0 = 8'h00;
        @(posedge clk);
        #1;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush_full();
        test_hold();
        test_mid_reset();
        test_noskid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
